video_pixel_shifter: RTL and testbench
======================================

VIDEO_PIXEL_SHIFTER -- requirements
Module: video_pixel_shifter

Interface
REQ-001 SHALL have parameter h_visible, default 1024, active pixels per line, multiple of 32.
REQ-002 SHALL have parameters h_front, h_sync, h_back, defaults 24, 136, 160, horizontal blanking widths in clocks.
REQ-003 SHALL have parameter v_visible, default 768, active lines per frame.
REQ-004 SHALL have parameters v_front, v_sync, v_back, defaults 3, 6, 29, vertical blanking widths in lines.
REQ-005 SHALL have parameter sync_active, default 1'b0, asserted level of hsync/vsync.
REQ-006 clk  input  1  pixel clock; one pixel per cycle; the only clock; all logic on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 q_data  input  32  word from the video queue, valid the cycle after q_rden.
REQ-009 q_empty  input  1  video queue empty flag.
REQ-010 q_rden  output  1  video queue read enable, one word per asserted cycle.
REQ-011 pixel  output  1  monochrome pixel, 1 = white.
REQ-012 de  output  1  data enable, high on active pixels.
REQ-013 hsync, vsync  output  1 each  sync pulses at sync_active level.
REQ-014 frame_start  output  1  one-cycle pulse telling the DMA to restart at framebuffer base.
REQ-015 underflow  output  1  sticky flag for a word missing when needed.

Function
REQ-016 hcnt SHALL count 0..h_total-1 with h_total = h_visible+h_front+h_sync+h_back, wrapping to 0.
REQ-017 vcnt SHALL increment when hcnt wraps and SHALL count 0..v_total-1 (v_total analogous), wrapping to 0.
REQ-018 Active region SHALL be hcnt < h_visible and vcnt < v_visible.
REQ-019 hsync SHALL be asserted for h_visible+h_front <= hcnt < h_visible+h_front+h_sync.
REQ-020 vsync SHALL be asserted for the vcnt range derived the same way from the vertical widths.
REQ-021 Prefetch: q_rden SHALL be high when hold_valid=0, no read is pending, and q_empty=0; the read is then pending for exactly one cycle.
REQ-022 In the cycle after q_rden, q_data SHALL be captured into the 32-bit hold register and hold_valid set.
REQ-023 Prefetch SHALL run in any region, active or blanking, so the first word of each line is ready beforehand.
REQ-024 At each active cycle with hcnt[4:0]=0, shift register SHALL load hold and clear hold_valid.
REQ-025 Otherwise, in active cycles the shift register SHALL shift right by one.
REQ-026 Pixel SHALL be bit 0 of the shift register, so word bit 0 is the leftmost pixel.
REQ-027 Underflow: at a load point with hold_valid=0, shift register SHALL load zero (black) and underflow SHALL set.
REQ-028 underflow SHALL stay set until reset.
REQ-029 Outside the active region, pixel SHALL be 0 and shifting SHALL stop.
REQ-030 frame_start SHALL pulse for one cycle when hcnt=0 and vcnt=v_visible (start of vertical blank).
REQ-031 pixel, de, hsync, vsync and frame_start SHALL be registered and mutually aligned, one cycle after the counter state that produces them.
REQ-032 Load and refill in the same cycle cannot occur, since q_rden requires hold_valid=0; at most one word is in flight.
REQ-033 Queue read latency SHALL be exactly one cycle (registered BRAM output), and no other handshake SHALL be used.

Reset
REQ-034 While rst_n=0 at a clock edge: hcnt=0, vcnt=0, hold_valid=0, pending=0, shift=0, underflow=0.
REQ-035 While rst_n=0 at a clock edge: q_rden=0, pixel=0, de=0, frame_start=0, hsync and vsync at the inactive level.
REQ-036 Reset mid-frame SHALL discard hold and pending data, and the frame SHALL restart at hcnt=vcnt=0.
REQ-037 The first q_rden SHALL occur no earlier than the first cycle after rst_n returns to 1.

Verification
Parameters for all scenarios: h_visible=64, h_front=4, h_sync=8, h_back=4, v_visible=4, v_front=1, v_sync=2, v_back=1, sync_active=0.
REQ-038 Timing: free-run 2 frames with queue always full -> de high 64 of every 80 clocks on vcnt 0..3; hsync low at hcnt 68..75; vsync low on lines 5..6; frame_start once per 640 clocks.
REQ-039 Pixel order: queue supplies 0x00000001 then 0x80000000 -> on line 0, pixel high only at active columns 0 and 63.
REQ-040 Underflow: q_empty held 1 from reset -> pixel stays 0, q_rden stays 0, underflow=1 from the first load point onward.
REQ-041 Prefetch: a single word becomes available during blanking -> exactly one q_rden pulse, hold captured the next cycle, no further reads until the next load point.
REQ-042 Reset mid-line: rst_n=0 for one cycle at hcnt=30, vcnt=2 -> all outputs at reset values the next cycle; underflow=0; the next frame_start arrives 4*80 clocks after release.

Source files
------------

// File: rtl/video_pixel_shifter_if.sv
// Purpose: bundles the video-queue read port and the raster output signals of video_pixel_shifter.
// Ports: q_data/q_empty come from the queue, q_rden goes back to it; pixel/de/hsync/vsync/frame_start/underflow go to the display side.
// The slave modport is the shifter; the master modport is whatever drives the queue and watches the raster.
interface video_pixel_shifter_if;
    logic [31:0] q_data;
    logic        q_empty;
    logic        q_rden;
    logic        pixel;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
    logic        underflow;

    modport master (
        output q_data, q_empty,
        input  q_rden, pixel, de, hsync, vsync, frame_start, underflow
    );

    modport slave (
        input  q_data, q_empty,
        output q_rden, pixel, de, hsync, vsync, frame_start, underflow
    );
endinterface

// File: rtl/video_pixel_shifter.sv
// Purpose: monochrome raster generator; shifts 32-pixel words from a 1-cycle-latency queue out LSB first.
// Latency: pixel/de/hsync/vsync/frame_start are registered, one clock after the counter state producing them.
// Backpressure: none toward the display; a missing word at a load point outputs black and sets sticky underflow.
// Ports: clk (pixel clock), rst_n (sync active-low), bus (slave modport: queue read port + raster outputs).
module video_pixel_shifter #(
    parameter int   h_visible   = 1024,
    parameter int   h_front     = 24,
    parameter int   h_sync      = 136,
    parameter int   h_back      = 160,
    parameter int   v_visible   = 768,
    parameter int   v_front     = 3,
    parameter int   v_sync      = 6,
    parameter int   v_back      = 29,
    parameter logic sync_active = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    video_pixel_shifter_if.slave  bus
);
    localparam int H_TOTAL = h_visible + h_front + h_sync + h_back;
    localparam int V_TOTAL = v_visible + v_front + v_sync + v_back;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_VIS    = HW'(h_visible);
    localparam logic [HW-1:0] H_SYNC_S = HW'(h_visible + h_front);
    localparam logic [HW-1:0] H_SYNC_E = HW'(h_visible + h_front + h_sync);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(v_visible);
    localparam logic [VW-1:0] V_SYNC_S = VW'(v_visible + v_front);
    localparam logic [VW-1:0] V_SYNC_E = VW'(v_visible + v_front + v_sync);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic [31:0]   r_hold;
    logic          r_hold_vld;
    logic          r_pend;
    logic [31:0]   r_shift;
    logic          r_pixel;
    logic          r_de;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_frame_start;
    logic          r_underflow;

    logic w_active;
    logic w_load;
    logic w_hsync_on;
    logic w_vsync_on;
    logic w_rden;

    assign w_active   = (r_hcnt < H_VIS) && (r_vcnt < V_VIS);
    // Each 32-pixel group starts on a hcnt multiple of 32 (h_visible is a multiple of 32).
    assign w_load     = w_active && (r_hcnt[4:0] == 5'd0);
    assign w_hsync_on = (r_hcnt >= H_SYNC_S) && (r_hcnt < H_SYNC_E);
    assign w_vsync_on = (r_vcnt >= V_SYNC_S) && (r_vcnt < V_SYNC_E);
    // Gating with rst_n keeps the queue untouched while reset is held.
    assign w_rden     = rst_n && !r_hold_vld && !r_pend && !bus.q_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_hold        <= '0;
            r_hold_vld    <= 1'b0;
            r_pend        <= 1'b0;
            r_shift       <= '0;
            r_pixel       <= 1'b0;
            r_de          <= 1'b0;
            r_hsync       <= ~sync_active;
            r_vsync       <= ~sync_active;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            if (r_hcnt == H_LAST) begin
                r_hcnt <= '0;
                r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + VW'(1);
            end else begin
                r_hcnt <= r_hcnt + HW'(1);
            end

            r_pend <= w_rden;

            // A pending read implies hold was empty, so a capture never clobbers an unloaded word;
            // the capture wins over a same-cycle load that found hold empty.
            if (r_pend) begin
                r_hold     <= bus.q_data;
                r_hold_vld <= 1'b1;
            end else if (w_load) begin
                r_hold_vld <= 1'b0;
            end

            // r_pixel always equals the bit that lands in r_shift[0] during active video.
            if (w_load) begin
                if (r_hold_vld) begin
                    r_shift <= r_hold;
                    r_pixel <= r_hold[0];
                end else begin
                    r_shift     <= '0;
                    r_pixel     <= 1'b0;
                    r_underflow <= 1'b1;
                end
            end else if (w_active) begin
                r_shift <= r_shift >> 1;
                r_pixel <= r_shift[1];
            end else begin
                r_pixel <= 1'b0;
            end

            r_de          <= w_active;
            r_hsync       <= w_hsync_on ? sync_active : ~sync_active;
            r_vsync       <= w_vsync_on ? sync_active : ~sync_active;
            r_frame_start <= (r_hcnt == '0) && (r_vcnt == V_VIS);
        end
    end

    assign bus.q_rden      = w_rden;
    assign bus.pixel       = r_pixel;
    assign bus.de          = r_de;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.frame_start = r_frame_start;
    assign bus.underflow   = r_underflow;
endmodule

// File: tb/tb_video_pixel_shifter.sv
// Purpose: directed self-checking bench for video_pixel_shifter on a small 64x4 raster (80 clocks x 8 lines).
// Latency: outputs are sampled on the falling edge; eh/ev name the counter state that produced them.
// Backpressure: the queue model answers q_rden with data one cycle later and counts every read.
module tb_video_pixel_shifter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    video_pixel_shifter_if vif();

    video_pixel_shifter #(
        .h_visible(64), .h_front(4), .h_sync(8), .h_back(4),
        .v_visible(4), .v_front(1), .v_sync(2), .v_back(1),
        .sync_active(1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Queue model: main writes wr_idx, the model alone writes rd_idx/pops.
    logic [31:0] words [16];
    int   wr_idx = 0;
    int   rd_idx = 0;
    int   pops = 0;
    bit   inf_full = 1'b0;
    logic rd_s;

    assign vif.q_empty = !inf_full && (wr_idx == rd_idx);

    initial begin
        vif.q_data = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            rd_s = vif.q_rden;
            @(posedge clk);
            #1;
            if (rd_s === 1'b1) begin
                pops++;
                if (rd_idx != wr_idx) begin
                    vif.q_data = words[rd_idx % 16];
                    rd_idx++;
                end else begin
                    vif.q_data = 32'hFFFF_FFFF;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    int eh, ev, nh, nv;

    task automatic step();
        @(negedge clk);
        eh = nh;
        ev = nv;
        if (nh == 79) begin
            nh = 0;
            nv = (nv == 7) ? 0 : nv + 1;
        end else begin
            nh++;
        end
    endtask

    // Called on a falling edge; holds reset for ncyc rising edges, checks reset outputs, releases.
    task automatic apply_reset(input string tag, input int ncyc);
        rst_n = 1'b0;
        repeat (ncyc) @(negedge clk);
        check_val({tag, "_rst_outs"},
                  {vif.pixel, vif.de, vif.frame_start, vif.hsync, vif.vsync, vif.underflow},
                  6'b000110);
        check_val({tag, "_rst_rden"}, vif.q_rden, 1'b0);
        rst_n = 1'b1;
        nh = 0;
        nv = 0;
    endtask

    initial begin
        int mism, de_n, hs_n, vs_n, fs_n, pix_n, last_fs, fs_gap, g, n, base, hi;
        logic exp_de, exp_hs, exp_vs, exp_fs, exp_px, col0, col63;

        // ---------- Timing with the queue always full ----------
        inf_full = 1'b1;
        @(negedge clk);
        apply_reset("a", 2);
        mism = 0; de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0; pix_n = 0;
        last_fs = -1; fs_gap = 0;
        for (int c = 0; c < 1280; c++) begin
            step();
            exp_de = (eh < 64) && (ev < 4);
            exp_hs = !((eh >= 68) && (eh < 76));
            exp_vs = !((ev >= 5) && (ev < 7));
            exp_fs = (eh == 0) && (ev == 4);
            if (vif.de !== exp_de || vif.hsync !== exp_hs || vif.vsync !== exp_vs ||
                vif.frame_start !== exp_fs || (!exp_de && vif.pixel !== 1'b0))
                mism++;
            de_n  += int'(vif.de);
            hs_n  += int'(!vif.hsync);
            vs_n  += int'(!vif.vsync);
            pix_n += int'(vif.pixel);
            if (vif.frame_start) begin
                fs_n++;
                if (last_fs >= 0) fs_gap = c - last_fs;
                last_fs = c;
            end
        end
        check_val("a_timing_mism", mism, 0);
        check_val("a_de_count", de_n, 512);
        check_val("a_hsync_low", hs_n, 128);
        check_val("a_vsync_low", vs_n, 320);
        check_val("a_fs_count", fs_n, 2);
        check_val("a_fs_gap", fs_gap, 640);
        // First group of frame 1 has no word yet (black); every later group is all-ones.
        check_val("a_white_px", pix_n, 480);

        // ---------- Reset mid-line at hcnt=30, vcnt=2 ----------
        g = 0;
        while (!(eh == 29 && ev == 2) && g < 2000) begin
            step();
            g++;
        end
        check_val("c_reach_line2", (g < 2000), 1'b1);
        apply_reset("c", 1);
        step();
        check_val("c_de_first", vif.de, 1'b1);
        // Hold was discarded by reset, so the first group after release underflows.
        check_val("c_uflow_first", vif.underflow, 1'b1);
        n = 0;
        while (vif.frame_start !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        check_val("c_fs_distance", n, 320);

        // ---------- Underflow, prefetch in blanking, pixel order ----------
        inf_full = 1'b0;
        wr_idx = rd_idx;
        apply_reset("b", 2);
        base = pops;
        step();
        check_val("b_uflow_first", vif.underflow, 1'b1);
        pix_n = int'(vif.pixel);
        mism = 0;
        g = 0;
        while (!(eh == 10 && ev == 4) && g < 2000) begin
            step();
            g++;
            pix_n += int'(vif.pixel);
            if (vif.underflow !== 1'b1) mism++;
        end
        check_val("b_empty_pixels", pix_n, 0);
        check_val("b_uflow_sticky", mism, 0);
        check_val("b_no_reads", pops - base, 0);

        words[wr_idx % 16] = 32'h0000_0001;
        wr_idx++;
        step();
        step();
        check_val("b_hold_vld", dut.r_hold_vld, 1'b1);
        check_val("b_hold_dat", dut.r_hold, 32'h0000_0001);
        repeat (10) step();
        check_val("b_one_read", pops - base, 1);

        words[wr_idx % 16] = 32'h8000_0000;
        wr_idx++;
        repeat (5) step();
        check_val("b_no_early_read", pops - base, 1);
        g = 0;
        while (!(eh == 0 && ev == 0) && g < 2000) begin
            step();
            g++;
        end
        check_val("b_pops_at_load", pops - base, 1);

        mism = 0; hi = 0; col0 = 1'b0; col63 = 1'b0;
        for (int col = 0; col < 64; col++) begin
            if (col > 0) step();
            exp_px = (eh == 0) || (eh == 63);
            if (vif.pixel !== exp_px) mism++;
            hi += int'(vif.pixel);
            if (eh == 0)  col0  = vif.pixel;
            if (eh == 63) col63 = vif.pixel;
        end
        check_val("b_line0_mism", mism, 0);
        check_val("b_line0_high", hi, 2);
        check_val("b_col0", col0, 1'b1);
        check_val("b_col63", col63, 1'b1);
        check_val("b_second_read", pops - base, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
